// File: rtl/lsu_dm_bridge.sv
// rtl/lsu_dm_bridge.sv - core load/store to word-organised data memory bridge with sub-word RMW
module lsu_dm_bridge #(
   parameter logic [31:0] DM_BASE = 32'h66000000,
   parameter logic [31:0] DM_LAST = 32'h660000FC
) (
   input  logic        clk_i,
   input  logic        reset,
   input  logic        core_req_i,
   input  logic        core_we_i,
   input  logic [2:0]  core_size_i,
   input  logic [31:0] core_addr_i,
   input  logic [31:0] core_wd_i,
   output logic [31:0] core_rd_o,
   output logic        core_stall_o,
   output logic        core_misalign_o,
   output logic        core_fault_o,
   output logic        mem_req_o,
   output logic        mem_we_o,
   output logic [2:0]  mem_size_o,
   output logic [31:0] a_o,
   output logic [31:0] wd_o,
   input  logic [31:0] rd_i
);

   typedef enum logic [1:0] {IDLE, LD_RESP, RMW_WR} state_t;

   localparam logic [2:0] SZ_B  = 3'b000;
   localparam logic [2:0] SZ_H  = 3'b001;
   localparam logic [2:0] SZ_W  = 3'b010;
   localparam logic [2:0] SZ_BU = 3'b100;
   localparam logic [2:0] SZ_HU = 3'b101;

   state_t      state;
   logic [31:0] cap_word;   // word read during the read phase
   logic [29:0] addr_q;     // word address of the accepted sub-word store
   logic [1:0]  off_q;      // byte offset of the accepted access
   logic        half_q;     // accepted sub-word store is a halfword
   logic [15:0] wd_q;       // store data, held so RMW_WR does not depend on the core
   logic [31:0] rd_q;

   logic size_ok, misalign, in_range, idle_req, accept, word_store, read_phase, rmw;
   logic [31:0] merged;

   // Extract the addressed lane from a word and extend it per funct3 size
   function automatic logic [31:0] extend(input logic [31:0] word, input logic [1:0] off,
                                          input logic [2:0] size);
      logic [31:0] s;
      s = word >> {off, 3'b000};
      case (size)
         SZ_B:    extend = {{24{s[7]}}, s[7:0]};
         SZ_H:    extend = {{16{s[15]}}, s[15:0]};
         SZ_BU:   extend = {24'h0, s[7:0]};
         SZ_HU:   extend = {16'h0, s[15:0]};
         default: extend = s;
      endcase
   endfunction

   // Request legality: size encoding, alignment and address range
   always_comb begin
      size_ok  = (core_size_i == SZ_B) || (core_size_i == SZ_H) || (core_size_i == SZ_W) ||
                 (core_size_i == SZ_BU) || (core_size_i == SZ_HU);
      misalign = !size_ok ||
                 ((core_size_i[1:0] == 2'b01) && core_addr_i[0]) ||
                 ((core_size_i == SZ_W) && (core_addr_i[1:0] != 2'b00));
      in_range = (core_addr_i >= DM_BASE) && (core_addr_i <= (DM_LAST + 32'd3));
      idle_req   = (state == IDLE) && core_req_i && !reset;
      accept     = idle_req && !misalign && in_range;
      word_store = accept && core_we_i && (core_size_i == SZ_W);
      read_phase = accept && !word_store;
      rmw        = (state == RMW_WR) && !reset;
   end

   // Replace the target byte or halfword of the captured word with the store data
   always_comb begin
      merged = cap_word;
      if (half_q) begin
         if (off_q[1]) merged[31:16] = wd_q;
         else          merged[15:0]  = wd_q;
      end else begin
         case (off_q)
            2'd0:    merged[7:0]   = wd_q[7:0];
            2'd1:    merged[15:8]  = wd_q[7:0];
            2'd2:    merged[23:16] = wd_q[7:0];
            default: merged[31:24] = wd_q[7:0];
         endcase
      end
   end

   // Core and DM side outputs; everything is gated off while reset is high
   always_comb begin
      core_misalign_o = idle_req && misalign;
      core_fault_o    = idle_req && !misalign && !in_range;
      core_stall_o    = read_phase;
      mem_req_o       = accept || rmw;
      mem_we_o        = word_store || rmw;
      mem_size_o      = SZ_W;
      a_o             = 32'h0;
      wd_o            = 32'h0;
      if (accept) begin
         a_o = {core_addr_i[31:2], 2'b00};
      end else if (rmw) begin
         a_o = {addr_q, 2'b00};
      end
      if (word_store) begin
         wd_o = core_wd_i;
      end else if (rmw) begin
         wd_o = merged;
      end
   end

   assign core_rd_o = rd_q;

   // Sequencer: capture on the read phase, respond or write back on the next cycle
   always_ff @(posedge clk_i or posedge reset) begin
      if (reset) begin
         state    <= IDLE;
         cap_word <= 32'h0;
         addr_q   <= 30'h0;
         off_q    <= 2'b00;
         half_q   <= 1'b0;
         wd_q     <= 16'h0;
         rd_q     <= 32'h0;
      end else begin
         case (state)
            IDLE: begin
               if (read_phase) begin
                  cap_word <= rd_i;
                  addr_q   <= core_addr_i[31:2];
                  off_q    <= core_addr_i[1:0];
                  half_q   <= core_size_i[0];
                  wd_q     <= core_wd_i[15:0];
                  if (core_we_i) begin
                     state <= RMW_WR;
                  end else begin
                     rd_q  <= extend(rd_i, core_addr_i[1:0], core_size_i);
                     state <= LD_RESP;
                  end
               end
            end
            LD_RESP: state <= IDLE;
            RMW_WR:  state <= IDLE;
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_lsu_dm_bridge.sv
// tb/tb_lsu_dm_bridge.sv - directed self-checking bench for lsu_dm_bridge
module tb_lsu_dm_bridge;

   logic        clk_i = 1'b0;
   logic        reset;
   logic        core_req_i;
   logic        core_we_i;
   logic [2:0]  core_size_i;
   logic [31:0] core_addr_i;
   logic [31:0] core_wd_i;
   logic [31:0] core_rd_o;
   logic        core_stall_o;
   logic        core_misalign_o;
   logic        core_fault_o;
   logic        mem_req_o;
   logic        mem_we_o;
   logic [2:0]  mem_size_o;
   logic [31:0] a_o;
   logic [31:0] wd_o;
   logic [31:0] rd_i;

   logic [31:0] dm [0:63];
   int checks = 0;
   int errors = 0;

   lsu_dm_bridge dut (
      .clk_i(clk_i), .reset(reset), .core_req_i(core_req_i), .core_we_i(core_we_i),
      .core_size_i(core_size_i), .core_addr_i(core_addr_i), .core_wd_i(core_wd_i),
      .core_rd_o(core_rd_o), .core_stall_o(core_stall_o), .core_misalign_o(core_misalign_o),
      .core_fault_o(core_fault_o), .mem_req_o(mem_req_o), .mem_we_o(mem_we_o),
      .mem_size_o(mem_size_o), .a_o(a_o), .wd_o(wd_o), .rd_i(rd_i)
   );

   always #5 clk_i = ~clk_i;

   // Word memory model: combinational read, write on the rising edge
   assign rd_i = dm[a_o[7:2]];
   always @(posedge clk_i) begin
      if (mem_req_o && mem_we_o) dm[a_o[7:2]] <= wd_o;
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
      end
   endtask

   task automatic drive(input logic req, input logic we, input logic [2:0] size,
                        input logic [31:0] addr, input logic [31:0] wd);
      core_req_i = req; core_we_i = we; core_size_i = size; core_addr_i = addr; core_wd_i = wd;
   endtask

   task automatic do_load(input string tag, input logic [2:0] size, input logic [31:0] addr,
                          input logic [31:0] exp);
      @(negedge clk_i);
      drive(1'b1, 1'b0, size, addr, 32'h0);
      #1;
      check({tag, "_stall"}, {31'h0, core_stall_o}, 32'h1);
      check({tag, "_req"}, {30'h0, mem_req_o, mem_we_o}, 32'h2);
      check({tag, "_addr"}, a_o, {addr[31:2], 2'b00});
      @(negedge clk_i);
      drive(1'b0, 1'b0, 3'b000, 32'h0, 32'h0);
      #1;
      check({tag, "_resp_stall"}, {31'h0, core_stall_o}, 32'h0);
      check({tag, "_rd"}, core_rd_o, exp);
   endtask

   task automatic do_sub_store(input string tag, input logic [2:0] size, input logic [31:0] addr,
                               input logic [31:0] wd, input logic [31:0] exp_wd);
      @(negedge clk_i);
      drive(1'b1, 1'b1, size, addr, wd);
      #1;
      check({tag, "_rd_stall"}, {31'h0, core_stall_o}, 32'h1);
      check({tag, "_rd_req"}, {30'h0, mem_req_o, mem_we_o}, 32'h2);
      @(negedge clk_i);
      drive(1'b0, 1'b0, 3'b000, 32'h0, 32'h0);
      #1;
      check({tag, "_wr_stall"}, {31'h0, core_stall_o}, 32'h0);
      check({tag, "_wr_req"}, {30'h0, mem_req_o, mem_we_o}, 32'h3);
      check({tag, "_wr_addr"}, a_o, {addr[31:2], 2'b00});
      check({tag, "_wd"}, wd_o, exp_wd);
   endtask

   task automatic do_bad(input string tag, input logic [2:0] size, input logic [31:0] addr,
                         input logic exp_mis, input logic exp_fault);
      @(negedge clk_i);
      drive(1'b1, 1'b0, size, addr, 32'h0);
      #1;
      check({tag, "_flags"}, {30'h0, core_misalign_o, core_fault_o}, {30'h0, exp_mis, exp_fault});
      check({tag, "_quiet"}, {30'h0, mem_req_o, core_stall_o}, 32'h0);
      @(negedge clk_i);
      drive(1'b0, 1'b0, 3'b000, 32'h0, 32'h0);
   endtask

   initial begin
      for (int i = 0; i < 64; i++) dm[i] = 32'h01010101 * i;
      dm[4]  = 32'h80817F22;
      dm[63] = 32'hA5B6C7D8;

      // Reset with a legal load pending: outputs must stay quiet
      reset = 1'b1;
      drive(1'b1, 1'b0, 3'b010, 32'h66000010, 32'h0);
      #12;
      check("rst_req", {30'h0, mem_req_o, mem_we_o}, 32'h0);
      check("rst_stall", {31'h0, core_stall_o}, 32'h0);
      check("rst_rd", core_rd_o, 32'h0);
      check("rst_size", {29'h0, mem_size_o}, 32'h2);
      check("rst_a", a_o, 32'h0);
      @(negedge clk_i);
      drive(1'b0, 1'b0, 3'b000, 32'h0, 32'h0);
      reset = 1'b0;
      #1;
      check("idle_quiet", {27'h0, mem_req_o, mem_we_o, core_stall_o, core_misalign_o, core_fault_o}, 32'h0);

      do_load("lb",  3'b000, 32'h66000012, 32'hFFFFFF81);
      do_load("lbu", 3'b100, 32'h66000012, 32'h00000081);
      do_load("lh",  3'b001, 32'h66000012, 32'hFFFF8081);
      do_load("lhu", 3'b101, 32'h66000012, 32'h00008081);
      do_load("lw",  3'b010, 32'h66000010, 32'h80817F22);

      do_sub_store("sb", 3'b000, 32'h66000011, 32'h000000AB, 32'h8081AB22);
      do_load("lw_sb", 3'b010, 32'h66000010, 32'h8081AB22);

      // Word store: single write cycle, no stall
      @(negedge clk_i);
      drive(1'b1, 1'b1, 3'b010, 32'h66000014, 32'hDEADBEEF);
      #1;
      check("sw_req", {30'h0, mem_req_o, mem_we_o}, 32'h3);
      check("sw_stall", {31'h0, core_stall_o}, 32'h0);
      check("sw_addr", a_o, 32'h66000014);
      check("sw_wd", wd_o, 32'hDEADBEEF);
      @(negedge clk_i);
      drive(1'b0, 1'b0, 3'b000, 32'h0, 32'h0);
      #1;
      check("sw_done", {30'h0, mem_req_o, mem_we_o}, 32'h0);

      do_sub_store("sh", 3'b001, 32'h66000016, 32'h0000CAFE, 32'hCAFEBEEF);
      do_load("lw_sh", 3'b010, 32'h66000014, 32'hCAFEBEEF);

      // Range edges
      do_load("lw_last", 3'b010, 32'h660000FC, 32'hA5B6C7D8);
      do_load("lbu_top", 3'b100, 32'h660000FF, 32'h000000A5);

      do_bad("lw_mis",  3'b010, 32'h66000012, 1'b1, 1'b0);
      do_bad("lh_mis",  3'b001, 32'h66000013, 1'b1, 1'b0);
      do_bad("sz_011",  3'b011, 32'h66000010, 1'b1, 1'b0);
      do_bad("lw_oor",  3'b010, 32'h66000100, 1'b0, 1'b1);
      do_bad("lb_low",  3'b000, 32'h65FFFFFF, 1'b0, 1'b1);

      // Reset while in RMW_WR: write suppressed, state back to IDLE
      @(negedge clk_i);
      drive(1'b1, 1'b1, 3'b001, 32'h66000012, 32'h00001234);
      @(negedge clk_i);
      reset = 1'b1;
      #1;
      check("rstw_we", {30'h0, mem_req_o, mem_we_o}, 32'h0);
      check("rstw_stall", {31'h0, core_stall_o}, 32'h0);
      check("rstw_rd", core_rd_o, 32'h0);
      @(negedge clk_i);
      drive(1'b0, 1'b0, 3'b000, 32'h0, 32'h0);
      reset = 1'b0;
      do_load("lw_after_rst", 3'b010, 32'h66000010, 32'h8081AB22);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/lsu_dm_bridge.md
Name: lsu_dm_bridge

Overview:
Load-store unit between the core's memory stage and the word-organised data memory (DM). It takes core load/store requests in RISC-V funct3 size encoding and issues word-aligned accesses to DM. It extracts bytes/halfwords from read data and sign- or zero-extends them. Sub-word stores become read-modify-write sequences because DM writes whole words only. Misaligned, illegal-size and out-of-range accesses are flagged and never reach DM.

Parameters:
DM_BASE, 32'h66000000, first byte address decoded by DM
DM_LAST, 32'h660000FC, last word address decoded by DM (inclusive)

Ports:
clk_i  in  1  clock, rising edge
reset  in  1  asynchronous reset, active-high
core_req_i  in  1  access request from the core (held stable while core_stall_o=1)
core_we_i  in  1  1=store, 0=load
core_size_i  in  3  funct3: 000 B, 001 H, 010 W, 100 BU, 101 HU
core_addr_i  in  32  byte address
core_wd_i  in  32  store data, right-justified
core_rd_o  out  32  extended load result
core_stall_o  out  1  core must hold the current instruction
core_misalign_o  out  1  misaligned or illegal-size access (combinational, in IDLE only)
core_fault_o  out  1  address outside DM_BASE..DM_LAST+3 (combinational, in IDLE only)
mem_req_o  out  1  DM access request
mem_we_o  out  1  DM write enable
mem_size_o  out  3  constant 3'b010 (word)
a_o  out  32  word address, core_addr_i with bits [1:0] forced to 0
wd_o  out  32  write data to DM
rd_i  in  32  DM read data, valid combinationally in the same cycle as a_o

Behaviour:
- Clock and reset: one clock, clk_i. Reset is asynchronous, active-high. While reset=1: state=IDLE, captured-word register=0, core_rd_o=0. All combinational outputs read 0, except mem_size_o, which stays 3'b010. mem_we_o drops in the same cycle reset rises.
- FSM states: IDLE, LD_RESP, RMW_WR.
- IDLE, core_req_i=0: all outputs 0 except mem_size_o.
- IDLE, request checks (priority order):
  - Illegal size (011, 110, 111) or misalignment → core_misalign_o=1, no mem_req_o, no stall, stay IDLE. Misaligned means H/HU with addr[0]=1, or W with addr[1:0]≠0.
  - Otherwise, address out of range → core_fault_o=1, no DM access, no stall.
- IDLE, load: mem_req_o=1, mem_we_o=0, core_stall_o=1. On the edge, capture rd_i and go to LD_RESP.
- LD_RESP:
  - core_stall_o=0, no DM access. core_req_i is ignored.
  - core_rd_o = captured word shifted right by 8*addr[1:0], then extended per size: B/H sign-extend, BU/HU zero-extend, W pass-through. The addr and size used are registered at request acceptance.
  - Next state IDLE. Load latency: request cycle plus one response cycle.
- IDLE, word store: mem_req_o=1, mem_we_o=1, wd_o=core_wd_i, no stall. Single cycle, stay IDLE.
- IDLE, byte/halfword store: read phase, identical to a load (stall=1, capture rd_i). Go to RMW_WR.
- RMW_WR:
  - mem_req_o=1, mem_we_o=1, core_stall_o=0.
  - wd_o = captured word with the target lane(s) replaced by core_wd_i[7:0] or core_wd_i[15:0] at byte offset addr[1:0]. All other bytes unchanged.
  - Next state IDLE. Sub-word store costs exactly 1 stall cycle.
- core_rd_o holds its last value outside LD_RESP. It is meaningful only in LD_RESP.
- Back-to-back accesses: a new request is accepted in the IDLE cycle directly after LD_RESP or RMW_WR. No bubble is added beyond that.
- core_req_i falling while in LD_RESP or RMW_WR: the sequence still completes; RMW_WR still writes.
- Reset mid-sequence: the sequence is aborted. No write occurs if reset is asserted before the RMW_WR edge.

Test Plan:
- DM[0x66000010]=0x80817F22. LB @0x66000012 → stall 1 cycle, then core_rd_o=0xFFFFFF81. LBU same address → 0x00000081.
- LH @0x66000012 → 0xFFFF8081. LHU → 0x00008081. LW @0x66000010 → 0x80817F22. Each has exactly one stall cycle.
- SB data 0x000000AB @0x66000011 → one read cycle (stall=1), then one write cycle with wd_o=0x8081AB22 and mem_we_o=1. DM then reads 0x8081AB22.
- SW 0xDEADBEEF @0x66000014 → mem_we_o=1 for one cycle, core_stall_o stays 0, a_o=0x66000014.
- Each of these → misalign=1 or fault=1 as listed, with mem_req_o=0 and core_stall_o=0:
  - LW @0x66000012 → misalign
  - LH @0x66000013 → misalign
  - size 3'b011 → misalign
  - LW @0x66000100 → fault
- Assert reset during RMW_WR → mem_we_o=0 in the same cycle. DM contents are unchanged, state is IDLE, core_stall_o=0, core_rd_o=0.
